// File: rtl/spi_pkg.sv
// ============================================================================
//  spi_pkg
//  Shared SPI definitions for the slave PHY and the command state machine:
//  command opcodes, the default idle MISO byte and the byte type used on the
//  PHY <-> command SM interface.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

   // One SPI byte as exchanged with the command state machine
   typedef logic [7:0] spi_byte_t;

   // Command opcodes recognised by the command state machine
   typedef enum logic [7:0] {
      SPI_OP_WRITE_8BIT_REG = 8'h87,
      SPI_OP_RX_DATA        = 8'h88,
      SPI_OP_RX_SD_DATA     = 8'h89,
      SPI_OP_READ_SD_FIFO   = 8'h8A
   } spi_opcode_e;

   // Byte driven on MISO when the command SM has nothing queued
   localparam spi_byte_t SPI_IDLE_TX = 8'hFF;

endpackage : spi_pkg

`default_nettype wire

// File: rtl/spi_slave_phy_if.sv
// ============================================================================
//  spi_slave_phy_if
//  Byte-level handshake between the SPI slave PHY and the command SM.
//  Ports (signals):
//    rx_data      PHY->SM  last complete received byte
//    rx_valid     PHY->SM  one-clk pulse, rx_data valid
//    tx_data      SM->PHY  response byte for the next byte slot
//    tx_load      SM->PHY  one-clk pulse, latch tx_data
//    tx_underrun  PHY->SM  one-clk pulse, slot started with nothing queued
//    busy         PHY->SM  high while chip select is active
//  Modports: slave (the PHY), master (the command SM)
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface spi_slave_phy_if;
   import spi_pkg::*;

   spi_byte_t rx_data;
   logic      rx_valid;
   spi_byte_t tx_data;
   logic      tx_load;
   logic      tx_underrun;
   logic      busy;

   modport slave (
      output rx_data,
      output rx_valid,
      input  tx_data,
      input  tx_load,
      output tx_underrun,
      output busy
   );

   modport master (
      input  rx_data,
      input  rx_valid,
      output tx_data,
      output tx_load,
      input  tx_underrun,
      input  busy
   );

endinterface : spi_slave_phy_if

`default_nettype wire

// File: rtl/cdc_sync.sv
// ============================================================================
//  cdc_sync
//  Single-bit multi-flop synchroniser into clk.
//  Ports:
//    clk   in  system clock
//    rst   in  synchronous active-high reset (flops take RST_VAL)
//    d_i   in  asynchronous input
//    q_o   out synchronised output
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cdc_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule : cdc_sync

`default_nettype wire

// File: rtl/spi_slave_phy.sv
// ============================================================================
//  spi_slave_phy
//  SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave front end. SCLK, CS_N and
//  MOSI are oversampled in clk; MOSI is deserialised into bytes for the
//  command SM and the SM's response byte is serialised onto MISO.
//  Ports:
//    clk, rst      system clock, synchronous active-high reset
//    spi_sclk      async SPI clock from master
//    spi_cs_n      async chip select, active low
//    spi_mosi      async master-out data
//    spi_miso      registered slave-out data
//    spi_miso_oe   MISO output enable (synchronised CS_N low)
//    sm            byte handshake to the command SM (slave modport)
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module spi_slave_phy
   import spi_pkg::*;
#(
   parameter int        SYNC_STAGES = 2,
   parameter spi_byte_t IDLE_TX     = SPI_IDLE_TX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   spi_slave_phy_if.slave        sm
);

   // ------------------------------------------------------------------
   // Pin synchronisers (reset to the idle bus levels)
   // ------------------------------------------------------------------
   logic s_sclk;
   logic s_cs_n;
   logic s_mosi;

   cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk (clk), .rst (rst), .d_i (spi_sclk), .q_o (s_sclk)
   );

   cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
      .clk (clk), .rst (rst), .d_i (spi_cs_n), .q_o (s_cs_n)
   );

   cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk (clk), .rst (rst), .d_i (spi_mosi), .q_o (s_mosi)
   );

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic       sclk_dly_q;
   logic       cs_n_dly_q;
   logic [2:0] bit_cnt_q,     bit_cnt_d;
   spi_byte_t  rx_shift_q,    rx_shift_d;
   spi_byte_t  rx_data_q,     rx_data_d;
   logic       rx_valid_q,    rx_valid_d;
   spi_byte_t  tx_shift_q,    tx_shift_d;
   spi_byte_t  tx_hold_q,     tx_hold_d;
   logic       tx_pending_q,  tx_pending_d;
   logic       tx_underrun_q, tx_underrun_d;
   logic       busy_q,        busy_d;

   // ------------------------------------------------------------------
   // Edge / frame event decode
   // ------------------------------------------------------------------
   logic sclk_rise;
   logic sclk_fall;
   logic frame_start;
   logic frame_end;
   logic in_frame;
   logic rise_ev;
   logic fall_ev;
   logic reload;

   assign sclk_rise   =  s_sclk & ~sclk_dly_q;
   assign sclk_fall   = ~s_sclk &  sclk_dly_q;
   assign frame_start =  cs_n_dly_q & ~s_cs_n;
   assign frame_end   = ~cs_n_dly_q &  s_cs_n;

   // SCLK edges count only inside a frame. A CS_N rise in the same clk
   // has s_cs_n=1 and so drops the edge; an edge coinciding with the
   // frame start is dropped as well so the start reload is not disturbed.
   assign in_frame = ~s_cs_n & ~frame_start;
   assign rise_ev  = sclk_rise & in_frame;
   assign fall_ev  = sclk_fall & in_frame;

   // A new byte slot begins at frame start and on the fall following
   // the 8th rise (counter has wrapped back to zero).
   assign reload = frame_start | (fall_ev & (bit_cnt_q == 3'd0));

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      tx_shift_d    = tx_shift_q;
      tx_hold_d     = tx_hold_q;
      tx_pending_d  = tx_pending_q;
      tx_underrun_d = 1'b0;
      busy_d        = ~s_cs_n;

      // Frame boundaries discard any partial byte
      if (frame_start || frame_end) begin
         bit_cnt_d = 3'd0;
      end

      if (rise_ev) begin
         rx_shift_d = {rx_shift_q[6:0], s_mosi};
         bit_cnt_d  = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q[6:0], s_mosi};
            rx_valid_d = 1'b1;
         end
      end

      if (sm.tx_load) begin
         tx_hold_d    = sm.tx_data;
         tx_pending_d = 1'b1;
      end

      if (reload) begin
         // A load arriving in the reload clk bypasses the holding register
         if (sm.tx_load) begin
            tx_shift_d   = sm.tx_data;
            tx_pending_d = 1'b0;
         end else if (tx_pending_q) begin
            tx_shift_d   = tx_hold_q;
            tx_pending_d = 1'b0;
         end else begin
            tx_shift_d    = IDLE_TX;
            tx_underrun_d = 1'b1;
         end
      end else if (fall_ev) begin
         tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_dly_q    <= 1'b0;
         cs_n_dly_q    <= 1'b1;
         bit_cnt_q     <= 3'd0;
         rx_shift_q    <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         tx_shift_q    <= IDLE_TX;
         tx_hold_q     <= '0;
         tx_pending_q  <= 1'b0;
         tx_underrun_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         sclk_dly_q    <= s_sclk;
         cs_n_dly_q    <= s_cs_n;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_shift_q    <= tx_shift_d;
         tx_hold_q     <= tx_hold_d;
         tx_pending_q  <= tx_pending_d;
         tx_underrun_q <= tx_underrun_d;
         busy_q        <= busy_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign spi_miso       = tx_shift_q[7];
   assign spi_miso_oe    = busy_q;
   assign sm.rx_data     = rx_data_q;
   assign sm.rx_valid    = rx_valid_q;
   assign sm.tx_underrun = tx_underrun_q;
   assign sm.busy        = busy_q;

endmodule : spi_slave_phy

`default_nettype wire
